// File: rtl/cr_rbus_ring_master.sv
// cr_rbus_ring_master: initiator at the head of the rbus register ring.
// Launches one strobe per request and waits for ack, err_ack or timeout.
`ifndef N_RBUS_ADDR_BITS
`define N_RBUS_ADDR_BITS 16
`endif
`ifndef N_RBUS_DATA_BITS
`define N_RBUS_DATA_BITS 32
`endif

package cr_rbus_pkg;
    typedef struct packed {
        logic                         wr_strb;
        logic                         rd_strb;
        logic [`N_RBUS_ADDR_BITS-1:0] addr;
        logic [`N_RBUS_DATA_BITS-1:0] wr_data;
        logic [`N_RBUS_DATA_BITS-1:0] rd_data;
        logic                         ack;
        logic                         err_ack;
    } rbus_ring_t;
endpackage

module cr_rbus_ring_master
    import cr_rbus_pkg::*;
#(
    parameter int N_RBUS_ADDR_BITS = `N_RBUS_ADDR_BITS,
    parameter int N_RBUS_DATA_BITS = `N_RBUS_DATA_BITS,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [N_RBUS_ADDR_BITS-1:0] req_addr,
    input  logic [N_RBUS_DATA_BITS-1:0] req_wr_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [N_RBUS_DATA_BITS-1:0] rsp_rd_data,
    output logic                        rsp_err,
    output logic                        rsp_timeout,
    output logic [7:0]                  stray_ack_cnt,
    output rbus_ring_t                  rbus_ring_o,
    input  rbus_ring_t                  rbus_ring_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                      state_q, state_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic                        wr_q, wr_d;
    logic [N_RBUS_ADDR_BITS-1:0] addr_q, addr_d;
    logic [N_RBUS_DATA_BITS-1:0] wdata_q, wdata_d;
    logic                        wr_strb_q, wr_strb_d;
    logic                        rd_strb_q, rd_strb_d;
    logic                        req_ready_q, req_ready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [N_RBUS_DATA_BITS-1:0] rsp_rd_data_q, rsp_rd_data_d;
    logic                        rsp_err_q, rsp_err_d;
    logic                        rsp_timeout_q, rsp_timeout_d;
    logic [7:0]                  stray_q, stray_d;
    logic                        hit;

    // Tail echoes of request fields carry no information for the head.
    logic unused_ring;
    assign unused_ring = ^{rbus_ring_i.wr_strb, rbus_ring_i.rd_strb,
                           rbus_ring_i.addr, rbus_ring_i.wr_data};

    assign hit = rbus_ring_i.ack | rbus_ring_i.err_ack;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wr_strb_d     = 1'b0;
        rd_strb_d     = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_rd_data_d = rsp_rd_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        stray_d       = stray_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d   = S_LAUNCH;
                    wr_d      = req_wr;
                    addr_d    = req_addr;
                    wdata_d   = req_wr_data;
                    wr_strb_d = req_wr;
                    rd_strb_d = !req_wr;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A reply in the expiry cycle takes priority over timeout.
                if (hit) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = rbus_ring_i.err_ack;
                    rsp_timeout_d = 1'b0;
                    if (!wr_q && !rbus_ring_i.err_ack)
                        rsp_rd_data_d = rbus_ring_i.rd_data;
                    else
                        rsp_rd_data_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rd_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_rd_data_d = '0;
                    addr_d        = '0;
                    wdata_d       = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hit && state_q != S_WAIT && stray_q != 8'hFF)
            stray_d = stray_q + 8'd1;

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_strb_q     <= 1'b0;
            rd_strb_q     <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_data_q <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wr_strb_q     <= wr_strb_d;
            rd_strb_q     <= rd_strb_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rd_data_q <= rsp_rd_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            stray_q       <= stray_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rd_data   = rsp_rd_data_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign stray_ack_cnt = stray_q;

    always_comb begin
        rbus_ring_o         = '0;
        rbus_ring_o.wr_strb = wr_strb_q;
        rbus_ring_o.rd_strb = rd_strb_q;
        rbus_ring_o.addr    = addr_q;
        rbus_ring_o.wr_data = wdata_q;
    end

endmodule

// File: doc/cr_rbus_ring_master.md
# cr_rbus_ring_master

Initiator end of the rbus register ring. Converts a single-outstanding request/response interface from the host-side controller into rbus_ring_t strobes launched at the ring head. It then watches the ring tail for the ack or err_ack returned by whichever cr_*_regfile node decodes the address. It enforces a response timeout and counts stray acks so that a hung or mis-addressed ring never stalls the controller.

## Interface
- N_RBUS_ADDR_BITS, default `N_RBUS_ADDR_BITS: rbus address width.
- N_RBUS_DATA_BITS, default `N_RBUS_DATA_BITS (32): rbus data width.
- TIMEOUT_CYCLES, default 1024: WAIT-state cycles before a transaction is aborted; legal range 2..65535.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  N_RBUS_ADDR_BITS  target address.
- req_wr_data  in  N_RBUS_DATA_BITS  write data; ignored for reads.
- rsp_valid  out  1  response available, held until taken.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rd_data  out  N_RBUS_DATA_BITS  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  err_ack received or timeout.
- rsp_timeout  out  1  timeout occurred (implies rsp_err).
- stray_ack_cnt  out  8  saturating count of acks/err_acks seen outside WAIT.
- rbus_ring_o  out  rbus_ring_t  ring head.
- rbus_ring_i  in  rbus_ring_t  ring tail.

## Operation
States and transitions:
- IDLE: req_ready = 1. On accept, capture req_wr, req_addr and req_wr_data, then go to LAUNCH.
- LAUNCH: exactly one cycle.
  - rbus_ring_o.wr_strb = req_wr and rbus_ring_o.rd_strb = !req_wr.
  - Clear the timeout counter, then go to WAIT.
- WAIT: strobes are 0. Sample rbus_ring_i each cycle.
  - ack or err_ack seen: capture rbus_ring_i.rd_data (reads only, and only if err_ack = 0) and set rsp_err = err_ack. Go to RESP.
  - ack and err_ack both high: treat as an error.
  - No ack: increment the counter. When it reaches TIMEOUT_CYCLES-1, set rsp_err = 1, rsp_timeout = 1 and rsp_rd_data = 0, then go to RESP.
  - An ack in the expiry cycle wins over the timeout.
- RESP: rsp_valid = 1. Go to IDLE on rsp_ready.

Ring output rules:
- rbus_ring_o.addr and wr_data hold the captured values from LAUNCH through RESP. Both are 0 in IDLE.
- rbus_ring_o.rd_data, ack and err_ack are always 0, since the master is the ring head.
- rbus_ring_i.wr_strb, rd_strb and addr echoed back from the tail are ignored.

Stray acks:
- An ack or err_ack at rbus_ring_i in IDLE, LAUNCH or RESP increments stray_ack_cnt, saturating at 255. The response is unchanged.
- A late ack that arrives after a timeout is counted as stray.

Other rules:
- All outputs are registered.
- rsp_* fields are stable while rsp_valid is high.

## Timing
- Reset value of every output is 0: req_ready, rsp_*, stray_ack_cnt and all rbus_ring_o fields. State resets to IDLE and the counter to 0.
- Reset mid-transaction abandons the transaction. Any ack arriving after reset release while in IDLE counts as stray.
- Cycle sequence:
  - Accept at cycle T.
  - Strobe visible on rbus_ring_o at T+1 (LAUNCH).
  - WAIT begins at T+2.
  - An ack sampled at cycle A gives rsp_valid at A+1.
  - With rsp_ready held high, req_ready returns at A+2.
- Ring round trip ≥ 1 cycle because nodes register. Minimum accept-to-rsp_valid latency is 3 cycles for a 1-cycle ring.
- Timeout: with no ack, rsp_valid rises at T+2+TIMEOUT_CYCLES.
- Back-to-back throughput is one transaction per (ring latency + 3) cycles, with one transaction outstanding at most.

## Test plan
- Write 0xDEADBEEF to 0x0040, with a node model acking 4 cycles after the strobe. Required:
  - one wr_strb pulse at T+1;
  - addr 0x0040 held through RESP;
  - rsp_err = 0 and rsp_rd_data = 0;
  - req_ready stays 0 until the response is taken.
- Read 0x0100, with the node returning rd_data 0x12345678 plus ack. Required: exactly one rd_strb pulse; rsp_rd_data = 0x12345678 and rsp_err = 0.
- Read with err_ack (data 0xFFFF) and, separately, with ack and err_ack both high. Both require rsp_err = 1, rsp_timeout = 0 and rsp_rd_data = 0.
- TIMEOUT_CYCLES = 8 with no ack. Required:
  - rsp_valid at T+10 with rsp_err = rsp_timeout = 1;
  - a late ack 3 cycles later sets stray_ack_cnt = 1;
  - the next request proceeds normally.
- Hold rsp_ready low for 20 cycles. Required: rsp_* stable, req_ready = 0, and acks injected in RESP counted as stray. Inject 300 stray acks: stray_ack_cnt saturates at 255.
- Assert rst_n low during WAIT. Required: all outputs 0 asynchronously and state IDLE; the node's subsequent ack counts as stray; a following read completes correctly.
